// File: rtl/ingress_scheduler.sv
// ingress_scheduler
//   Buffers each cycle's retired commit group (valid mask + 4 uop entries)
//   in a FIFO of groups. The head group is presented to ingress_fsm and
//   advances on pop_i. A small FSM sequences enable / drain / flush of the
//   trace ingress path. Groups arriving while the FIFO is full are dropped
//   and counted.
// Optional feature: define INGRESS_SCHED_BYPASS_EN to let a group pushed
//   into an empty FIFO drive the head outputs combinationally in the same
//   cycle. If it is popped in that cycle it is never stored.
// Ports
//   clk_i, rst_i        clock, async active-high reset
//   enable_i, flush_i   path enable, discard all buffered groups
//   commit_valid_i      per-lane retire valid (lane0 = A)
//   commit_uop_i        per-lane uop entries
//   pop_i               head consumed
//   ivalids_o           head mask, bit[N-1]=A ... bit0=D
//   uop_a_o..uop_d_o    head entries, lanes 0..3
//   valid_o, level_o    head present, groups buffered
//   overflow_o          sticky drop flag, cleared by flush
//   drop_cnt_o          saturating dropped-group count
//   busy_o              FSM not idle

package ingress_scheduler_pkg;
  typedef struct packed {
    logic [3:0]  itype;
    logic [31:0] pc;
  } uop_entry_s;
  localparam logic [3:0] ITYPE_STD = 4'd2;
endpackage

module ingress_scheduler
  import ingress_scheduler_pkg::*;
#(
  parameter int NrRetiredInstr = 4,
  parameter int Depth          = 8,
  parameter int CntW           = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 enable_i,
  input  logic                                 flush_i,
  input  logic [NrRetiredInstr-1:0]            commit_valid_i,
  input  uop_entry_s [NrRetiredInstr-1:0]      commit_uop_i,
  input  logic                                 pop_i,
  output logic [NrRetiredInstr-1:0]            ivalids_o,
  output uop_entry_s                           uop_a_o,
  output uop_entry_s                           uop_b_o,
  output uop_entry_s                           uop_c_o,
  output uop_entry_s                           uop_d_o,
  output logic                                 valid_o,
  output logic [$clog2(Depth):0]               level_o,
  output logic                                 overflow_o,
  output logic [CntW-1:0]                      drop_cnt_o,
  output logic                                 busy_o
);
  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [NrRetiredInstr-1:0]       mask;
    uop_entry_s [NrRetiredInstr-1:0] uop;
  } grp_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;

  state_t          r_state, w_state_nxt;
  grp_t            r_mem [Depth];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [LW-1:0]   r_level, w_level_nxt;
  logic            r_ovf;
  logic [CntW-1:0] r_drop;

  grp_t w_in, w_out;
  logic w_empty, w_full, w_push_req, w_push, w_pop, w_drop, w_byp, w_byp_pop;

  // Stored mask is in output order: lane0 (A) lands in the MSB.
  always_comb begin
    w_in = '0;
    for (int i = 0; i < NrRetiredInstr; i++) begin
      w_in.mask[NrRetiredInstr-1-i] = commit_valid_i[i];
      w_in.uop[i]                   = commit_uop_i[i];
    end
  end

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LW'(Depth));
  assign w_push_req = (r_state == S_RUN) && enable_i && (|commit_valid_i) && !flush_i;

`ifdef INGRESS_SCHED_BYPASS_EN
  assign w_byp     = w_empty && w_push_req;
  assign w_byp_pop = w_byp && pop_i;
`else
  assign w_byp     = 1'b0;
  assign w_byp_pop = 1'b0;
`endif

  assign w_pop  = !w_empty && pop_i && !flush_i;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push = w_push_req && (!w_full || w_pop) && !w_byp_pop;
  assign w_drop = w_push_req && w_full && !w_pop;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LW'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LW'(1);
  end

  // FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) w_state_nxt = S_FLUSH;
    else begin
      case (r_state)
        S_FLUSH: w_state_nxt = enable_i ? S_RUN : S_IDLE;
        S_IDLE:  if (enable_i) w_state_nxt = S_RUN;
        S_RUN:   if (!enable_i) w_state_nxt = (w_level_nxt != '0) ? S_DRAIN : S_IDLE;
        S_DRAIN: begin
          if (w_level_nxt == '0) w_state_nxt = S_IDLE;
          else if (enable_i)     w_state_nxt = S_RUN;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Pointers, level, drop accounting
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nxt;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + CntW'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_in;
  end

  always_comb begin
    w_out = '0;
    if (w_byp)         w_out = w_in;
    else if (!w_empty) w_out = r_mem[r_rptr];
  end

  assign ivalids_o  = w_out.mask;
  assign uop_a_o    = w_out.uop[0];
  assign uop_b_o    = w_out.uop[1];
  assign uop_c_o    = w_out.uop[2];
  assign uop_d_o    = w_out.uop[3];
  assign valid_o    = !w_empty || w_byp;
  assign level_o    = r_level;
  assign overflow_o = r_ovf;
  assign drop_cnt_o = r_drop;
  assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_ingress_scheduler.sv
module tb_ingress_scheduler;
  import ingress_scheduler_pkg::*;

  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable_i, flush_i, pop_i;
  logic [3:0]       commit_valid_i;
  uop_entry_s [3:0] commit_uop_i;
  logic [3:0]       ivalids_o;
  uop_entry_s       uop_a_o, uop_b_o, uop_c_o, uop_d_o;
  logic             valid_o, overflow_o, busy_o;
  logic [3:0]       level_o;
  logic [15:0]      drop_cnt_o;

  ingress_scheduler #(.NrRetiredInstr(4), .Depth(DEPTH), .CntW(16)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable_i), .flush_i(flush_i),
    .commit_valid_i(commit_valid_i), .commit_uop_i(commit_uop_i), .pop_i(pop_i),
    .ivalids_o(ivalids_o), .uop_a_o(uop_a_o), .uop_b_o(uop_b_o),
    .uop_c_o(uop_c_o), .uop_d_o(uop_d_o), .valid_o(valid_o), .level_o(level_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_FLUSH} mst_t;

  int           n_cmp = 0;
  int           n_err = 0;
  mst_t         m_st;
  logic [147:0] q[$];
  int           m_drop;
  bit           m_ovf;
  logic [147:0] first_grp;

  task automatic chk(input string tag, input logic [147:0] obs, input logic [147:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [147:0] obs_grp();
    return {ivalids_o, uop_d_o, uop_c_o, uop_b_o, uop_a_o};
  endfunction

  task automatic status(input string tag);
    chk({tag, "_level"}, 148'(level_o), 148'(q.size()));
    chk({tag, "_valid"}, 148'(valid_o), 148'(q.size() != 0));
    chk({tag, "_ovf"},   148'(overflow_o), 148'(m_ovf));
    chk({tag, "_drop"},  148'(drop_cnt_o), 148'(m_drop));
    chk({tag, "_busy"},  148'(busy_o), 148'(m_st != M_IDLE));
    if (q.size() != 0) chk({tag, "_head"}, obs_grp(), q[0]);
    else               chk({tag, "_empty"}, obs_grp(), 148'(0));
  endtask

  // One clock of stimulus; the model advances alongside and checks after the edge.
  task automatic cycle(input logic [3:0] v, input bit p, input bit en, input bit fl);
    logic [147:0] exp_in;
    bit acc, popok, byp_pop;
    int pre;
    mst_t nst;
    enable_i = en; flush_i = fl; pop_i = p; commit_valid_i = v;
    for (int i = 0; i < 4; i++) begin
      commit_uop_i[i].itype = (i == 0) ? ITYPE_STD : 4'($urandom_range(0, 15));
      commit_uop_i[i].pc    = $urandom;
    end
    #1;
    exp_in  = {v[0], v[1], v[2], v[3], commit_uop_i[3], commit_uop_i[2], commit_uop_i[1], commit_uop_i[0]};
    acc     = (m_st == M_RUN) && en && (v != 0) && !fl;
    byp_pop = 0;
`ifdef INGRESS_SCHED_BYPASS_EN
    if (q.size() == 0 && acc) begin
      chk("bypass_valid", 148'(valid_o), 148'(1));
      chk("bypass_data", obs_grp(), exp_in);
      byp_pop = p;
    end
`endif
    pre   = q.size();
    popok = (pre != 0) && p && !fl;
    if (popok) begin
      chk("pop_head", obs_grp(), q[0]);
      void'(q.pop_front());
    end
    if (acc && !byp_pop) begin
      if (pre == DEPTH && !popok) begin
        m_ovf = 1;
        if (m_drop != 16'hFFFF) m_drop++;
      end else q.push_back(exp_in);
    end
    if (fl) begin q.delete(); m_drop = 0; m_ovf = 0; end
    nst = m_st;
    if (fl) nst = M_FLUSH;
    else case (m_st)
      M_FLUSH: nst = en ? M_RUN : M_IDLE;
      M_IDLE:  if (en) nst = M_RUN;
      M_RUN:   if (!en) nst = (q.size() != 0) ? M_DRAIN : M_IDLE;
      M_DRAIN: if (q.size() == 0) nst = M_IDLE; else if (en) nst = M_RUN;
      default: nst = M_IDLE;
    endcase
    m_st = nst;
    @(posedge clk); #1;
    commit_valid_i = '0; pop_i = 0; flush_i = 0;
    #1;
    status("cyc");
  endtask

  initial begin
    rst = 1; enable_i = 0; flush_i = 0; pop_i = 0; commit_valid_i = '0; commit_uop_i = '0;
    m_st = M_IDLE; m_drop = 0; m_ovf = 0;
    #12;
    status("reset");
    @(negedge clk); rst = 0;

    // enable, single push: lane A only
    cycle(4'b0000, 0, 1, 0);
    cycle(4'b0001, 0, 1, 0);
    chk("single_ivalids", 148'(ivalids_o), 148'(4'b1000));
    chk("single_valid", 148'(valid_o), 148'(1));
    chk("single_itype", 148'(uop_a_o.itype), 148'(ITYPE_STD));
    cycle(4'b0000, 1, 1, 0);
    chk("single_popped_level", 148'(level_o), 148'(0));

    // fill to overflow
    for (int i = 0; i < 10; i++) begin
      cycle(4'($urandom_range(1, 15)), 0, 1, 0);
      if (i == 0) first_grp = q[0];
    end
    chk("fill_level", 148'(level_o), 148'(8));
    chk("fill_drop", 148'(drop_cnt_o), 148'(2));
    chk("fill_ovf", 148'(overflow_o), 148'(1));
    chk("fill_head_first", obs_grp(), first_grp);

    // push and pop together while full
    cycle(4'b1111, 1, 1, 0);
    chk("fullpp_level", 148'(level_o), 148'(8));
    chk("fullpp_drop", 148'(drop_cnt_o), 148'(2));

    // drain from level 3
    repeat (5) cycle(4'b0000, 1, 1, 0);
    chk("pre_drain_level", 148'(level_o), 148'(3));
    cycle(4'b0000, 0, 0, 0);
    chk("drain_busy", 148'(busy_o), 148'(1));
    cycle(4'b1111, 0, 0, 0);
    chk("drain_nopush", 148'(level_o), 148'(3));
    repeat (3) cycle(4'b0000, 1, 0, 0);
    chk("drain_done_level", 148'(level_o), 148'(0));
    chk("drain_idle", 148'(busy_o), 148'(0));

    // flush at level 5 with overflow set, pop asserted alongside
    cycle(4'b0000, 0, 1, 0);
    repeat (9) cycle(4'($urandom_range(1, 15)), 0, 1, 0);
    repeat (3) cycle(4'b0000, 1, 1, 0);
    chk("pre_flush_level", 148'(level_o), 148'(5));
    chk("pre_flush_ovf", 148'(overflow_o), 148'(1));
    cycle(4'b0110, 1, 1, 1);
    chk("flush_level", 148'(level_o), 148'(0));
    chk("flush_ovf", 148'(overflow_o), 148'(0));
    chk("flush_drop", 148'(drop_cnt_o), 148'(0));
    cycle(4'b0000, 0, 1, 0);
    cycle(4'b1010, 0, 1, 0);
    chk("post_flush_run", 148'(level_o), 148'(1));
    cycle(4'b0000, 1, 1, 0);

`ifdef INGRESS_SCHED_BYPASS_EN
    cycle(4'b1111, 1, 1, 0);
    chk("bypass_level", 148'(level_o), 148'(0));
`endif

    // async reset mid-drain
    repeat (3) cycle(4'b0011, 0, 1, 0);
    cycle(4'b0000, 0, 0, 0);
    chk("rst_pre_busy", 148'(busy_o), 148'(1));
    #2 rst = 1;
    #1;
    q.delete(); m_st = M_IDLE; m_drop = 0; m_ovf = 0;
    status("async_rst");
    #3 rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
